// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: frame state encoding, parity-mode
//                codes, standard baud divisors and the parity helper used by
//                the transmit path (and later by the receive path).
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // 50 MHz / 5208 is roughly 9600 baud; the short divisor keeps simulations fast.
  localparam int CLK_DIV_9600_50M = 5208;
  localparam int CLK_DIV_SIM      = 8;

  // xor_acc is the XOR of all data bits; odd parity inverts it so the total
  // number of ones (data + parity) comes out odd.
  function automatic logic parity_bit(input logic xor_acc, input int mode);
    return (mode == PAR_ODD) ? ~xor_acc : xor_acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame_if
//  Description : Producer-side bundle of the UART transmitter.
//                master : word producer (drives din / wr_en)
//                slave  : transmitter (drives status and the serial line)
//  Ports       : din, wr_en, full, overflow, fifo_count, uart_txd,
//                clk_tx_en, busy, done
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
interface uart_tx_frame_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] din;
  logic                 wr_en;
  logic                 full;
  logic                 overflow;
  logic [c_CNT_W-1:0]   fifo_count;
  logic                 uart_txd;
  logic                 clk_tx_en;
  logic                 busy;
  logic                 done;

  modport master (
    output din, wr_en,
    input  full, overflow, fifo_count, uart_txd, clk_tx_en, busy, done
  );

  modport slave (
    input  din, wr_en,
    output full, overflow, fifo_count, uart_txd, clk_tx_en, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Single-clock FIFO with occupancy count. Pointers wrap
//                naturally (DEPTH is a power of two); the count register
//                tells full from empty. The read data is the current head,
//                valid whenever empty_o is low (show-ahead).
//  Ports       : clk, rst (async, active-high)
//                wr_en_i, din_i   - push request and data
//                rd_en_i, dout_o  - pop request and head word
//                full_o, empty_o, count_o, overflow_o (dropped-push pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_AW:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             w_push, w_pop;

  assign full_o  = (count_q == (c_AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // Full is judged on the pre-pop occupancy: a push against a full FIFO is
  // dropped even when a pop frees a slot in the same cycle.
  assign w_push = wr_en_i & ~full_o;
  assign w_pop  = rd_en_i & ~empty_o;

  always_comb begin
    wr_ptr_d   = w_push ? wr_ptr_q + c_AW'(1) : wr_ptr_q;
    rd_ptr_d   = w_pop  ? rd_ptr_q + c_AW'(1) : rd_ptr_q;
    overflow_d = wr_en_i & full_o;
    count_d    = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (c_AW+1)'(1);
      2'b01:   count_d = count_q - (c_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o     = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame
//  Description : Parametrised UART transmitter with input FIFO. Frames are
//                start, DATA_BITS data bits LSB first, optional parity and
//                STOP_BITS stop bits, each CLK_DIV cycles long. Buffered
//                words are sent back to back with no idle bit between frames.
//  Ports       : clk, rst (async, active-high)
//                bus (uart_tx_frame_if.slave):
//                  din/wr_en in; full, overflow, fifo_count, uart_txd,
//                  clk_tx_en, busy, done out
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_9600_50M,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_frame_if.slave bus
);
  localparam logic [12:0] c_BAUD_LAST = 13'(CLK_DIV - 1);
  localparam logic [3:0]  c_BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic        c_STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [12:0]          baud_q, baud_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;

  logic                 w_tick;
  logic                 w_pop;
  logic                 w_done;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_head;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.wr_en),
    .din_i      (bus.din),
    .rd_en_i    (w_pop),
    .dout_o     (w_head),
    .full_o     (bus.full),
    .empty_o    (w_empty),
    .overflow_o (bus.overflow),
    .count_o    (bus.fifo_count)
  );

  assign w_tick = (state_q != IDLE) && (baud_q == c_BAUD_LAST);

  // txd_d is the value the line takes next cycle, so the line register
  // already holds the right bit on the first cycle of every bit period.
  // par_q accumulates the XOR of each data bit as it is put on the line.
  always_comb begin
    state_d    = state_q;
    baud_d     = (state_q == IDLE || w_tick) ? 13'd0 : baud_q + 13'd1;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    txd_d      = txd_q;
    w_pop      = 1'b0;
    w_done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = START;
          shift_d = w_head;
          par_d   = 1'b0;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          state_d   = DATA;
          bit_idx_d = 4'd0;
          txd_d     = shift_q[0];
          par_d     = shift_q[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (bit_idx_q == c_BIT_LAST) begin
            if (PARITY != PAR_NONE) begin
              state_d = PAR;
              txd_d   = parity_bit(par_q, PARITY);
            end else begin
              state_d    = STOP;
              stop_idx_d = 1'b0;
              txd_d      = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
            par_d     = par_q ^ shift_q[1];
          end
        end
      end
      PAR: begin
        if (w_tick) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          txd_d      = 1'b1;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (stop_idx_q == c_STOP_LAST) begin
            w_done = 1'b1;
            // Chain straight into the next start bit when a word is waiting.
            if (!w_empty) begin
              w_pop   = 1'b1;
              state_d = START;
              shift_d = w_head;
              par_d   = 1'b0;
              txd_d   = 1'b0;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= 13'd0;
      bit_idx_q  <= 4'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
    end
  end

  assign bus.uart_txd  = txd_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.clk_tx_en = w_tick;
  assign bus.done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_frame
//  Description : Self-checking bench for uart_tx_frame. Three instances
//                (8N1, 8E1, 7O2) are driven one at a time; expected line,
//                status and FIFO behaviour come from a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int c_DIV   = CLK_DIV_SIM;
  localparam int c_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_BITS(8), .FIFO_DEPTH(c_DEPTH)) if_a ();
  uart_tx_frame_if #(.DATA_BITS(8), .FIFO_DEPTH(c_DEPTH)) if_b ();
  uart_tx_frame_if #(.DATA_BITS(7), .FIFO_DEPTH(c_DEPTH)) if_c ();

  uart_tx_frame #(.CLK_DIV(c_DIV), .DATA_BITS(8), .PARITY(PAR_NONE),
                  .STOP_BITS(1), .FIFO_DEPTH(c_DEPTH))
    u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  uart_tx_frame #(.CLK_DIV(c_DIV), .DATA_BITS(8), .PARITY(PAR_EVEN),
                  .STOP_BITS(1), .FIFO_DEPTH(c_DEPTH))
    u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  uart_tx_frame #(.CLK_DIV(c_DIV), .DATA_BITS(7), .PARITY(PAR_ODD),
                  .STOP_BITS(2), .FIFO_DEPTH(c_DEPTH))
    u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  logic [2:0] m_txd, m_busy, m_done, m_txen, m_full, m_ovf;
  logic [2:0] m_cnt [3];
  assign m_txd  = {if_c.uart_txd,  if_b.uart_txd,  if_a.uart_txd};
  assign m_busy = {if_c.busy,      if_b.busy,      if_a.busy};
  assign m_done = {if_c.done,      if_b.done,      if_a.done};
  assign m_txen = {if_c.clk_tx_en, if_b.clk_tx_en, if_a.clk_tx_en};
  assign m_full = {if_c.full,      if_b.full,      if_a.full};
  assign m_ovf  = {if_c.overflow,  if_b.overflow,  if_a.overflow};
  assign m_cnt[0] = if_a.fifo_count;
  assign m_cnt[1] = if_b.fifo_count;
  assign m_cnt[2] = if_c.fifo_count;

  int tests = 0;
  int fails = 0;
  int p_db   [3] = '{8, 8, 7};
  int p_par  [3] = '{PAR_NONE, PAR_EVEN, PAR_ODD};
  int p_stop [3] = '{1, 1, 2};
  logic [8:0] wq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input int s);
    return c_DIV * (1 + p_db[s] + ((p_par[s] != PAR_NONE) ? 1 : 0) + p_stop[s]);
  endfunction

  // k-th bit period of the frame carrying word w on instance s.
  function automatic logic ref_bit(input int s, input logic [8:0] w, input int k);
    logic x;
    x = 1'b0;
    for (int i = 0; i < p_db[s]; i++) x ^= w[i];
    if (k == 0) return 1'b0;
    if (k <= p_db[s]) return w[k-1];
    if (p_par[s] != PAR_NONE && k == p_db[s] + 1)
      return (p_par[s] == PAR_EVEN) ? x : ~x;
    return 1'b1;
  endfunction

  task automatic drive(input int s, input logic wr, input logic [8:0] d);
    if_a.wr_en = (s == 0) && wr;  if_a.din = d[7:0];
    if_b.wr_en = (s == 1) && wr;  if_b.din = d[7:0];
    if_c.wr_en = (s == 2) && wr;  if_c.din = d[6:0];
  endtask

  // Pushes wq[0..] on consecutive cycles into instance s and checks every
  // cycle for ncyc cycles against a frame-level model of FIFO and line.
  task automatic run_seq(input int s, input int ncyc);
    int         fl;
    int         pop_ready;
    int         off;
    int         pre;
    logic       wr;
    logic       ovf_next;
    logic       e_txd, e_busy, e_done, e_en;
    logic [8:0] fifo_m [$];
    int         fstart [$];
    logic [8:0] fword  [$];
    fl        = frame_len(s);
    pop_ready = 0;
    ovf_next  = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      wr = (c < wq.size());
      drive(s, wr, wr ? wq[c] : 9'd0);
      @(negedge clk);
      e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_en = 1'b0;
      foreach (fstart[i]) begin
        if (c >= fstart[i] && c < fstart[i] + fl) begin
          off    = c - fstart[i];
          e_txd  = ref_bit(s, fword[i], off / c_DIV);
          e_busy = 1'b1;
          e_done = (off == fl - 1);
          e_en   = ((off % c_DIV) == c_DIV - 1);
        end
      end
      chk($sformatf("d%0d c%0d txd",   s, c), 32'(m_txd[s]),  32'(e_txd));
      chk($sformatf("d%0d c%0d busy",  s, c), 32'(m_busy[s]), 32'(e_busy));
      chk($sformatf("d%0d c%0d done",  s, c), 32'(m_done[s]), 32'(e_done));
      chk($sformatf("d%0d c%0d txen",  s, c), 32'(m_txen[s]), 32'(e_en));
      chk($sformatf("d%0d c%0d count", s, c), 32'(m_cnt[s]),  32'(fifo_m.size()));
      chk($sformatf("d%0d c%0d full",  s, c), 32'(m_full[s]), 32'(fifo_m.size() == c_DEPTH));
      chk($sformatf("d%0d c%0d ovf",   s, c), 32'(m_ovf[s]),  32'(ovf_next));
      // End-of-cycle model update: full and empty judged on pre-update size.
      pre      = fifo_m.size();
      ovf_next = wr && (pre == c_DEPTH);
      if (pre > 0 && c >= pop_ready) begin
        fstart.push_back(c + 1);
        fword.push_back(fifo_m.pop_front());
        pop_ready = c + fl;
      end
      if (wr && pre < c_DEPTH) fifo_m.push_back(wq[c]);
    end
    drive(s, 1'b0, 9'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 9'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst d%0d txd",   s), 32'(m_txd[s]),  32'd1);
      chk($sformatf("rst d%0d busy",  s), 32'(m_busy[s]), 32'd0);
      chk($sformatf("rst d%0d done",  s), 32'(m_done[s]), 32'd0);
      chk($sformatf("rst d%0d txen",  s), 32'(m_txen[s]), 32'd0);
      chk($sformatf("rst d%0d full",  s), 32'(m_full[s]), 32'd0);
      chk($sformatf("rst d%0d ovf",   s), 32'(m_ovf[s]),  32'd0);
      chk($sformatf("rst d%0d count", s), 32'(m_cnt[s]),  32'd0);
    end

    // Single frames: 8N1, 8E1 and 7O2.
    wq = '{9'h037};  run_seq(0, 90);
    wq = '{9'h037};  run_seq(1, 96);
    wq = '{9'h020};  run_seq(2, 96);

    // Back-to-back frames.
    wq = '{9'h037, 9'h020};  run_seq(0, 170);

    // Overflow: six pushes in six cycles into a depth-4 FIFO.
    wq.delete();
    for (int i = 0; i < 6; i++) wq.push_back(9'($urandom_range(0, 255)));
    run_seq(0, 420);

    // Random bursts on the parity instances.
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(9'($urandom_range(0, 255)));
    run_seq(1, 280);
    wq.delete();
    for (int i = 0; i < 2; i++) wq.push_back(9'($urandom_range(0, 127)));
    run_seq(2, 190);

    // Reset in the middle of a data bit with a second word still queued.
    @(posedge clk); #1 drive(0, 1'b1, 9'($urandom_range(0, 255)));
    @(posedge clk); #1 drive(0, 1'b1, 9'($urandom_range(0, 255)));
    @(posedge clk); #1 drive(0, 1'b0, 9'd0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("pre-rst busy", 32'(m_busy[0]), 32'd1);
    chk("pre-rst count", 32'(m_cnt[0]), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst-mid txd",   32'(m_txd[0]),  32'd1);
    chk("rst-mid busy",  32'(m_busy[0]), 32'd0);
    chk("rst-mid done",  32'(m_done[0]), 32'd0);
    chk("rst-mid count", 32'(m_cnt[0]),  32'd0);
    @(negedge clk);
    chk("rst-hold done", 32'(m_done[0]), 32'd0);
    chk("rst-hold txd",  32'(m_txd[0]),  32'd1);
    @(posedge clk);
    #2 rst = 1'b0;

    // Transmission after reset release.
    wq = '{9'($urandom_range(0, 255))};
    run_seq(0, 90);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised successor to the fixed 8N1 UART transmitter. Serialises buffered words onto `uart_txd` with configurable baud divisor, data width, parity and stop-bit count. An internal FIFO allows back-to-back frames without idle gaps. It sits between the system-side byte producer and the board TX pin, on the single system clock domain.

## Interface

**Parameters**
- `CLK_DIV`, 5208: clock cycles per bit. 50 MHz / 5208 ≈ 9600 baud; simulation uses 8. Legal range is 2 to 8191 (13-bit counter).
- `DATA_BITS`, 8: data bits per frame. Legal range is 5 to 9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame. Legal values are 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries. Must be a power of 2 and at least 2.

**Ports**
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset. Asynchronous, active-high.
- `din` in `DATA_BITS`: word to transmit.
- `wr_en` in 1: push `din` into the FIFO this cycle.
- `full` out 1: FIFO full. A `wr_en` while full is dropped.
- `overflow` out 1: one-cycle pulse when a `wr_en` is dropped.
- `fifo_count` out clog2(`FIFO_DEPTH`)+1: number of words currently buffered.
- `uart_txd` out 1: serial line. Registered. Idles high.
- `clk_tx_en` out 1: one-cycle pulse at each bit boundary while a frame is active.
- `busy` out 1: high from the first cycle of the start bit through the last cycle of the final stop bit.
- `done` out 1: one-cycle pulse on the last cycle of each frame's final stop bit.

## Operation

**States:** IDLE, START, DATA, PAR, STOP.
- IDLE → START when the FIFO is not empty. The head word is popped into the shift register in the same cycle.
- START → DATA after 1 bit period.
- DATA: shifts LSB-first for `DATA_BITS` periods. A bit index counts 0 to `DATA_BITS`-1.
- DATA → PAR if `PARITY`≠0, else DATA → STOP.
- PAR lasts 1 period.
  - Even mode: parity bit = XOR of the data bits.
  - Odd mode: parity bit = inverted XOR.
- STOP lasts `STOP_BITS` periods, with the line driven high.
- At the end of STOP:
  - FIFO not empty → START directly, with no idle bit. The pop happens in that same cycle.
  - FIFO empty → IDLE.

**Baud counter**
- Counts 0 to `CLK_DIV`-1 and is forced to 0 whenever a frame starts.
- `clk_tx_en` is high when the counter equals `CLK_DIV`-1 in any non-IDLE state.
- Every bit is exactly `CLK_DIV` cycles long, the first included.
- Frame length in cycles = `CLK_DIV` × (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`).

**FIFO**
- `full` is evaluated before any same-cycle pop. A push with `full`=1 is dropped, even if a pop happens in that cycle, and `overflow` pulses.
- A push and pop in the same cycle on a non-full, non-empty FIFO leaves `fifo_count` unchanged.
- A push into an empty FIFO while IDLE starts the frame on the following cycle.
- Pointers wrap modulo `FIFO_DEPTH`. A count register distinguishes full from empty.

**Reset values:** all asynchronous.
- `uart_txd`=1, `busy`=0, `done`=0, `clk_tx_en`=0, `overflow`=0, `full`=0, `fifo_count`=0.
- State = IDLE, FIFO emptied.
- Reset mid-frame aborts the frame immediately. The line returns high with no partial stop bit and no `done` pulse.

## Timing

- Cycle N: `wr_en`=1 into an empty FIFO while IDLE.
- N+1: pop, with IDLE → START.
- N+2: `uart_txd`=0 and `busy`=1. The start bit occupies cycles N+2 through N+2+`CLK_DIV`-1.
- `done` coincides with the last `clk_tx_en` of the frame.
- Back-to-back frames: the next start bit begins on the cycle after `done`, and `busy` stays high throughout.
- `fifo_count` updates the cycle after a push or pop.

## Structure

- Shared package `uart_pkg`:
  - state enum (IDLE/START/DATA/PAR/STOP)
  - parity-mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
  - 9600-baud divisor constant for 50 MHz (5208) and simulation divisor (8)
- Sub-module `uart_sync_fifo`: parameters `WIDTH` and `DEPTH`; ports wr_en, rd_en, full, empty, count. It will be reused by the future RX path.
- The top level holds the FSM, baud counter, shift register and parity accumulator.

## Test plan

All scenarios use `CLK_DIV`=8.
- **8N1 frame.** Push 0x37. Within 2 cycles `uart_txd` drives bits 0,1,1,1,0,1,1,0,0,1, each 8 cycles long. `done` pulses once at cycle 80 of the frame and `busy` drops the next cycle.
- **Parity.** `PARITY`=2 with 0x37 gives parity bit 1 and an 88-cycle frame. `PARITY`=1 gives parity bit 0. `DATA_BITS`=7 with 0x20 gives a 7-bit LSB-first payload 0,0,0,0,0,1,0.
- **Back-to-back.** Push 0x37 then 0x20 on consecutive cycles. The two frames abut with no high gap beyond the stop bit, `busy` stays high for 160 cycles, and there are two `done` pulses 80 cycles apart.
- **Overflow.** Push 6 words with `FIFO_DEPTH`=4 in 6 consecutive cycles. The first is popped at once and 4 are buffered. `full`=1, one `overflow` pulse marks the 6th push, which is never transmitted, and 5 frames follow.
- **Reset mid-frame.** Assert `rst` during a data bit. `uart_txd`=1 and `busy`=0 in the same cycle. No `done`, and `fifo_count`=0. After release, a new push transmits correctly.
- **Two stop bits.** `STOP_BITS`=2, 8N2, 0xFF. The line is low only during the start bit, and the frame is 88 cycles.
